// File: rtl/sti_dac_pkg.sv
// Shared types and decode helpers for the serial transmitter / data arrange controller.
package sti_dac_pkg;

    typedef enum logic [1:0] {
        Len8  = 2'b00,
        Len16 = 2'b01,
        Len24 = 2'b10,
        Len32 = 2'b11
    } len_e;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StPad,
        StDone
    } state_e;

    // Frame length in bits for a length code.
    function automatic logic [5:0] frame_bits(input len_e len);
        logic [5:0] n;
        n = 6'd8;
        case (len)
            Len8:    n = 6'd8;
            Len16:   n = 6'd16;
            Len24:   n = 6'd24;
            Len32:   n = 6'd32;
            default: n = 6'd8;
        endcase
        return n;
    endfunction

    // One-hot strobe for pixel n: [3:0] = odd1..odd4, [7:4] = even1..even4.
    // Bank comes from n[7:6]; checkerboard parity from n[0]^n[3].
    function automatic logic [7:0] bank_decode(input logic [7:0] n);
        logic [2:0] idx;
        idx = {~(n[0] ^ n[3]), n[7:6]};
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/sti_dac_oem_writer.sv
// Packs the serial stream into pixel bytes and writes them to the checkerboard
// memories; zero-fills the remaining pixels on request.
module sti_dac_oem_writer
    import sti_dac_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    input  logic       pad,
    output logic [4:0] oem_addr,
    output logic [7:0] oem_dataout,
    output logic [7:0] wr,
    output logic       all_written,
    output logic       oem_finish
);

    logic [6:0] byte_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] pix_q;
    logic [7:0] wr_q;
    logic [4:0] addr_q;
    logic [7:0] data_q;
    logic       all_written_q;
    logic       finish_q;

    logic       byte_done;
    logic       pad_wr;
    logic       wr_en;
    logic [7:0] wr_byte;

    // Decide whether this cycle issues a pixel write and what byte it carries.
    always_comb begin
        byte_done = so_valid && !all_written_q && (bit_cnt_q == 3'd7);
        pad_wr    = pad && !so_valid && !all_written_q;
        wr_en     = byte_done || pad_wr;
        wr_byte   = byte_done ? {byte_q, so_data} : 8'h00;
    end

    // Byte packer, pixel counter and registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q        <= '0;
            bit_cnt_q     <= '0;
            pix_q         <= '0;
            wr_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            all_written_q <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            wr_q     <= '0;
            finish_q <= all_written_q;
            if (so_valid && !all_written_q) begin
                byte_q    <= {byte_q[5:0], so_data};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (wr_en) begin
                wr_q          <= bank_decode(pix_q);
                addr_q        <= pix_q[5:1];
                data_q        <= wr_byte;
                pix_q         <= pix_q + 8'd1;
                all_written_q <= (pix_q == 8'd255);
            end
        end
    end

    assign oem_addr    = addr_q;
    assign oem_dataout = data_q;
    assign wr          = wr_q;
    assign all_written = all_written_q;
    assign oem_finish  = finish_q;

endmodule

// File: rtl/sti_dac.sv
// Serial transmitter: frame build, serializer and control FSM; feeds the OEM writer.
module sti_dac
    import sti_dac_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] pi_data,
    input  logic [1:0]  pi_length,
    input  logic        pi_fill,
    input  logic        pi_msb,
    input  logic        pi_low,
    input  logic        pi_end,
    output logic        so_data,
    output logic        so_valid,
    output logic [4:0]  oem_addr,
    output logic [7:0]  oem_dataout,
    output logic        odd1_wr,
    output logic        odd2_wr,
    output logic        odd3_wr,
    output logic        odd4_wr,
    output logic        even1_wr,
    output logic        even2_wr,
    output logic        even3_wr,
    output logic        even4_wr,
    output logic        oem_finish
);

    state_e      state_q, state_d;
    logic [31:0] sreg_q;
    logic [5:0]  cnt_q;
    logic        msb_q;
    logic        so_data_q;
    logic        so_valid_q;

    len_e        len;
    logic [31:0] frame;
    logic [31:0] aligned;
    logic [5:0]  nbits;
    logic        load_ok;
    logic        all_written;
    logic [7:0]  wr;

    assign len     = len_e'(pi_length);
    assign load_ok = load && (state_q == StIdle);

    // Build the right-justified frame; MSB-first frames are also left-aligned to bit 31.
    always_comb begin
        frame = '0;
        case (len)
            Len8:    frame = {24'h0, pi_low ? pi_data[15:8] : pi_data[7:0]};
            Len16:   frame = {16'h0, pi_data};
            Len24:   frame = pi_fill ? {8'h0, pi_data, 8'h00} : {16'h0, pi_data};
            Len32:   frame = pi_fill ? {pi_data, 16'h0000} : {16'h0, pi_data};
            default: frame = '0;
        endcase
        nbits   = frame_bits(len);
        aligned = frame << (6'd32 - nbits);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StSend;
                end else if (pi_end) begin
                    state_d = StPad;
                end
            end
            StSend: begin
                if (cnt_q == 6'd0) begin
                    state_d = pi_end ? StPad : StIdle;
                end
            end
            StPad: begin
                if (all_written) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Serializer: the first bit goes out with the capture edge, so cnt_q counts bits still to send.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q     <= '0;
            cnt_q      <= '0;
            msb_q      <= 1'b0;
            so_data_q  <= 1'b0;
            so_valid_q <= 1'b0;
        end else if (load_ok) begin
            so_valid_q <= 1'b1;
            so_data_q  <= pi_msb ? aligned[31] : frame[0];
            sreg_q     <= pi_msb ? (aligned << 1) : (frame >> 1);
            cnt_q      <= nbits - 6'd1;
            msb_q      <= pi_msb;
        end else if (state_q == StSend) begin
            if (cnt_q != 6'd0) begin
                so_data_q <= msb_q ? sreg_q[31] : sreg_q[0];
                sreg_q    <= msb_q ? (sreg_q << 1) : (sreg_q >> 1);
                cnt_q     <= cnt_q - 6'd1;
            end else begin
                so_valid_q <= 1'b0;
                so_data_q  <= 1'b0;
            end
        end
    end

    assign so_data  = so_data_q;
    assign so_valid = so_valid_q;

    sti_dac_oem_writer u_oem_writer (
        .clk         (clk),
        .reset       (reset),
        .so_data     (so_data_q),
        .so_valid    (so_valid_q),
        .pad         (state_q == StPad),
        .oem_addr    (oem_addr),
        .oem_dataout (oem_dataout),
        .wr          (wr),
        .all_written (all_written),
        .oem_finish  (oem_finish)
    );

    assign odd1_wr  = wr[0];
    assign odd2_wr  = wr[1];
    assign odd3_wr  = wr[2];
    assign odd4_wr  = wr[3];
    assign even1_wr = wr[4];
    assign even2_wr = wr[5];
    assign even3_wr = wr[6];
    assign even4_wr = wr[7];

endmodule

// File: tb/tb_sti_dac.sv
// Bench for sti_dac: directed and random frames checked against a bit/pixel-level model.
module tb_sti_dac;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        so_data;
    logic        so_valid;
    logic [4:0]  oem_addr;
    logic [7:0]  oem_dataout;
    logic        odd1_wr, odd2_wr, odd3_wr, odd4_wr;
    logic        even1_wr, even2_wr, even3_wr, even4_wr;
    logic        oem_finish;

    sti_dac dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .pi_data     (pi_data),
        .pi_length   (pi_length),
        .pi_fill     (pi_fill),
        .pi_msb      (pi_msb),
        .pi_low      (pi_low),
        .pi_end      (pi_end),
        .so_data     (so_data),
        .so_valid    (so_valid),
        .oem_addr    (oem_addr),
        .oem_dataout (oem_dataout),
        .odd1_wr     (odd1_wr),
        .odd2_wr     (odd2_wr),
        .odd3_wr     (odd3_wr),
        .odd4_wr     (odd4_wr),
        .even1_wr    (even1_wr),
        .even2_wr    (even2_wr),
        .even3_wr    (even3_wr),
        .even4_wr    (even4_wr),
        .oem_finish  (oem_finish)
    );

    always #5 clk = ~clk;

    wire [7:0] wr_vec = {even4_wr, even3_wr, even2_wr, even1_wr,
                         odd4_wr, odd3_wr, odd2_wr, odd1_wr};

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] vec;
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         m_pix;
    int         m_cnt;
    logic [7:0] m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Strobe expected for pixel n, in wr_vec bit order.
    function automatic logic [7:0] exp_vec(input int n);
        int bank;
        int odd;
        bank = n / 64;
        odd  = (n % 2) ^ ((n / 8) % 2);
        return 8'(1 << (odd != 0 ? bank : bank + 4));
    endfunction

    function automatic longint unsigned frame_of(input logic [15:0] d, input logic [1:0] len,
                                                 input logic fill, input logic low);
        longint unsigned v;
        v = 64'(d);
        case (len)
            2'd0:    return low ? (v >> 8) : (v & 64'hff);
            2'd1:    return v;
            2'd2:    return fill ? (v << 8) : v;
            default: return fill ? (v << 16) : v;
        endcase
    endfunction

    task automatic model_reset();
        m_pix = 0;
        m_cnt = 0;
        m_acc = '0;
        exp_q.delete();
    endtask

    // One serial bit into the pixel model; a completed byte becomes an expected write.
    task automatic feed(input logic b);
        wr_t e;
        if (m_pix < 256) begin
            m_acc = {m_acc[6:0], b};
            m_cnt++;
            if (m_cnt == 8) begin
                e.vec  = exp_vec(m_pix);
                e.addr = 5'((m_pix / 2) % 32);
                e.data = m_acc;
                exp_q.push_back(e);
                m_pix++;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step_raw();
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes();
        wr_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_strobe", 32'(wr_vec), 32'(e.vec));
            chk("oem_addr", 32'(oem_addr), 32'(e.addr));
            chk("oem_dataout", 32'(oem_dataout), 32'(e.data));
        end else begin
            chk("wr_idle", 32'(wr_vec), 32'd0);
        end
    endtask

    task automatic step();
        step_raw();
        check_writes();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_so_data"}, 32'(so_data), 32'd0);
        chk({tag, "_so_valid"}, 32'(so_valid), 32'd0);
        chk({tag, "_addr"}, 32'(oem_addr), 32'd0);
        chk({tag, "_data"}, 32'(oem_dataout), 32'd0);
        chk({tag, "_wr"}, 32'(wr_vec), 32'd0);
        chk({tag, "_finish"}, 32'(oem_finish), 32'd0);
    endtask

    // Load one frame and check every serial bit; glitch pulses a load mid-frame that must be ignored.
    task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                        input logic msb, input logic low, input logic glitch, input logic last);
        longint unsigned f;
        int              nb;
        logic            b;
        f  = frame_of(d, len, fill, low);
        nb = 8 * (int'(len) + 1);
        pi_data   = d;
        pi_length = len;
        pi_fill   = fill;
        pi_msb    = msb;
        pi_low    = low;
        load      = 1'b1;
        step();
        load      = 1'b0;
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom);
        pi_fill   = ~fill;
        pi_msb    = ~msb;
        pi_low    = ~low;
        if (last) pi_end = 1'b1;
        for (int k = 0; k < nb; k++) begin
            b = msb ? f[nb - 1 - k] : f[k];
            chk("so_valid", 32'(so_valid), 32'd1);
            chk("so_data", 32'(so_data), 32'(b));
            feed(b);
            load = (glitch && k == 2);
            step();
        end
        load = 1'b0;
        chk("so_valid_low", 32'(so_valid), 32'd0);
    endtask

    initial begin
        int budget;
        int r;
        reset     = 1'b1;
        load      = 1'b0;
        pi_data   = '0;
        pi_length = '0;
        pi_fill   = 1'b0;
        pi_msb    = 1'b0;
        pi_low    = 1'b0;
        pi_end    = 1'b0;
        model_reset();
        step_raw();
        step_raw();
        check_zero("reset");
        reset = 1'b0;

        // Directed frame formats.
        send(16'hA5C3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send(16'hA5C3, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'hA5C3, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'hA5C3, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'hA5C3, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'hA5C3, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Abort a frame with reset; everything restarts at pixel 0.
        pi_data   = 16'hFFFF;
        pi_length = 2'b11;
        pi_msb    = 1'b1;
        load      = 1'b1;
        step_raw();
        load = 1'b0;
        step_raw();
        step_raw();
        reset = 1'b1;
        step_raw();
        check_zero("midreset");
        reset = 1'b0;
        model_reset();

        // Checkerboard bytes 11..AA from pixel 0.
        for (int i = 1; i <= 10; i++) begin
            send(16'(i * 17), 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Random frames up to exactly 96 pixels, pi_end raised during the last one.
        while (m_pix < 92) begin
            send(16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'b0);
        end
        r = 96 - m_pix;
        send(16'($urandom), 2'(r - 1), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);

        // Zero padding, one pixel per cycle, then finish.
        budget = 0;
        step_raw();
        while (wr_vec == 8'd0 && budget < 8) begin
            step_raw();
            budget++;
        end
        for (int p = m_pix; p < 256; p++) begin
            chk("pad_strobe", 32'(wr_vec), 32'(exp_vec(p)));
            chk("pad_addr", 32'(oem_addr), 32'((p / 2) % 32));
            chk("pad_data", 32'(oem_dataout), 32'd0);
            chk("finish_early", 32'(oem_finish), 32'd0);
            step_raw();
        end
        chk("finish_rise", 32'(oem_finish), 32'd1);
        chk("finish_wr_idle", 32'(wr_vec), 32'd0);
        step_raw();
        step_raw();
        step_raw();
        chk("finish_hold", 32'(oem_finish), 32'd1);
        chk("done_wr_idle", 32'(wr_vec), 32'd0);
        chk("done_so_valid", 32'(so_valid), 32'd0);

        reset = 1'b1;
        step_raw();
        check_zero("final_reset");
        reset  = 1'b0;
        pi_end = 1'b0;
        step_raw();
        chk("finish_after_reset", 32'(oem_finish), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
